// File: rtl/mem_requester_if.sv
// Pipeline-side and memory-side signals of mem_requester, grouped in one bundle.
// master: the requester itself; slave: the pipeline stages and memory that surround it.
interface mem_requester_if;
    logic        if_req;
    logic [31:0] if_adr;
    logic        if_rdy;
    logic [31:0] if_data;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_adr;
    logic [31:0] ls_wdata;
    logic [2:0]  ls_siz;
    logic        ls_rdy;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic        I_start;
    logic [31:0] I_adr;
    logic        I_busy;
    logic        I_done;
    logic [31:0] I_out;

    logic        D_start;
    logic [31:0] D_adr;
    logic        D_load;
    logic [31:0] D_in;
    logic [2:0]  D_siz;
    logic        D_busy;
    logic        D_done;
    logic [31:0] D_out;

    modport master (
        input  if_req, if_adr, ls_req, ls_we, ls_adr, ls_wdata, ls_siz,
        input  I_busy, I_done, I_out, D_busy, D_done, D_out,
        output if_rdy, if_data, ls_rdy, ls_rdata, ls_err,
        output I_start, I_adr, D_start, D_adr, D_load, D_in, D_siz
    );

    modport slave (
        output if_req, if_adr, ls_req, ls_we, ls_adr, ls_wdata, ls_siz,
        output I_busy, I_done, I_out, D_busy, D_done, D_out,
        input  if_rdy, if_data, ls_rdy, ls_rdata, ls_err,
        input  I_start, I_adr, D_start, D_adr, D_load, D_in, D_siz
    );
endinterface

// File: rtl/mem_requester.sv
// Arbitrates IF fetches and MEM loads/stores onto the memory's I/D start/busy/done ports.
// Optional watchdog abort enabled by defining MEMREQ_TIMEOUT_EN.
module mem_requester #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic            clk,
    input logic            rst,
    mem_requester_if.master bus
);

    typedef enum logic [2:0] {StIdle, StIReq, StIWait, StDReq, StDWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] i_adr_q;
    logic [31:0] d_adr_q;
    logic [31:0] d_wdata_q;
    logic        d_we_q;
    logic [2:0]  d_siz_q;
    logic        resp_ls_q;
    logic [31:0] if_data_q;
    logic [31:0] ls_rdata_q;
    logic        ls_err_q;

    logic ls_misaligned;
    logic i_fin;
    logic d_fin;
    logic timeout;
    logic abort;

    assign ls_misaligned = (bus.ls_siz[1:0] == 2'b01 && bus.ls_adr[0]) ||
                           (bus.ls_siz[1:0] == 2'b10 && bus.ls_adr[1:0] != 2'b00);
    // Only meaningful in *_WAIT, which is entered after busy was seen high: stale done is ignored.
    assign i_fin = !bus.I_busy && bus.I_done;
    assign d_fin = !bus.D_busy && bus.D_done;

`ifdef MEMREQ_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        in_xfer;

    assign in_xfer = (state_q == StIReq) || (state_q == StIWait) ||
                     (state_q == StDReq) || (state_q == StDWait);
    assign timeout = in_xfer && (cnt_q == TIMEOUT_CYC - 32'd1);

    always_comb begin
        cnt_d = '0;
        if (in_xfer && state_d == state_q) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    // Watchdog compiled out; the parameter is kept so both builds share one instantiation.
    assign timeout = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    // A normal completion on the abort edge wins over the watchdog.
    assign abort = timeout && !(state_q == StIWait && i_fin) && !(state_q == StDWait && d_fin);

    function automatic logic [31:0] load_ext(input logic [2:0] siz, input logic [31:0] d);
        case (siz)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'b0, d[7:0]};
            3'b101:  return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.ls_req)      state_d = ls_misaligned ? StResp : StDReq;
                else if (bus.if_req) state_d = StIReq;
            end
            StIReq:  if (bus.I_busy) state_d = StIWait;
            StIWait: if (i_fin)      state_d = StResp;
            StDReq:  if (bus.D_busy) state_d = StDWait;
            StDWait: if (d_fin)      state_d = StResp;
            StResp:                  state_d = StIdle;
            default:                 state_d = StIdle;
        endcase
        if (timeout) state_d = StResp;
    end

    always_comb begin
        bus.I_start = 1'b0;
        bus.D_start = 1'b0;
        bus.if_rdy  = 1'b0;
        bus.ls_rdy  = 1'b0;
        unique case (state_q)
            StIReq: bus.I_start = 1'b1;
            StDReq: bus.D_start = 1'b1;
            StResp: begin
                if (resp_ls_q) bus.ls_rdy = 1'b1;
                else           bus.if_rdy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_adr_q    <= '0;
            d_adr_q    <= '0;
            d_wdata_q  <= '0;
            d_we_q     <= 1'b0;
            d_siz_q    <= '0;
            resp_ls_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            ls_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.ls_req) begin
                        resp_ls_q <= 1'b1;
                        if (ls_misaligned) begin
                            ls_err_q   <= 1'b1;
                            ls_rdata_q <= '0;
                        end else begin
                            d_adr_q   <= bus.ls_adr;
                            d_wdata_q <= bus.ls_wdata;
                            d_we_q    <= bus.ls_we;
                            d_siz_q   <= bus.ls_siz;
                        end
                    end else if (bus.if_req) begin
                        resp_ls_q <= 1'b0;
                        i_adr_q   <= bus.if_adr;
                    end
                end
                StIWait: if (i_fin) if_data_q <= bus.I_out;
                StDWait: begin
                    if (d_fin) begin
                        ls_rdata_q <= d_we_q ? 32'h0 : load_ext(d_siz_q, bus.D_out);
                        ls_err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (abort) begin
                if (resp_ls_q) begin
                    ls_err_q   <= 1'b1;
                    ls_rdata_q <= '0;
                end else begin
                    if_data_q <= 32'h0000_0013;
                end
            end
        end
    end

    assign bus.I_adr    = i_adr_q;
    assign bus.D_adr    = d_adr_q;
    assign bus.D_in     = d_wdata_q;
    assign bus.D_load   = d_we_q;
    assign bus.D_siz    = d_siz_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_rdata = ls_rdata_q;
    assign bus.ls_err   = ls_err_q;

endmodule
